out_uart_tx: RTL and testbench

- Downstream consumer of the CPU top's 16-bit `data_out` (the memory-controller output register).
- Detects every change of the observed word and queues it in a small FIFO.
- Serializes each queued word as two UART 8N1 bytes, high byte first, on one `tx` line for the host debug console.
- Replaces ad-hoc LED observation of results with a streamed log.

---
 rtl/cpu_uart_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/out_uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_out_uart_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_uart_pkg.sv
// -----------------------------------------------------------------------------
// cpu_uart_pkg
// Shared types and constants for the CPU debug-console UART peripherals.
//   uart_state_t : transmitter FSM states (PARITY is used only when
//                  OUT_UART_PARITY_EN is defined)
//   byte_sel_t   : which half of the 16-bit word is being sent
//   DATA_BITS, START_BIT, STOP_BIT, IDLE_LEVEL : UART framing constants
//   even_parity(): XOR of a data byte
// -----------------------------------------------------------------------------
package cpu_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    typedef enum logic {
        BYTE_LO = 1'b0,
        BYTE_HI = 1'b1
    } byte_sel_t;

    localparam int   DATA_BITS  = 8;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO: rdata always presents the oldest word, pop
// consumes it. Depth is 2**FIFO_AW. A push while full is accepted only when a
// pop happens in the same cycle; otherwise it is ignored (the caller decides
// what to do about the lost word).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset (empties the FIFO)
//   push   : write wdata
//   pop    : consume rdata (ignored when empty)
//   wdata  : write data
//   rdata  : oldest stored word (valid when !empty)
//   full   : count == depth
//   empty  : count == 0
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH   = 16,
    parameter int FIFO_AW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (FIFO_AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a word if one leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; reset is synchronous and checked first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly FIFO_AW bits wide, so they wrap modulo depth.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count and pointers alone
    // decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/out_uart_tx.sv
// -----------------------------------------------------------------------------
// out_uart_tx
// Watches the CPU's 16-bit data_out word, queues every change in a small FIFO
// and streams each queued word to the debug console as two UART bytes, high
// byte first, LSB first within a byte, CLK_DIV clocks per bit.
// Build option: define OUT_UART_PARITY_EN for 8E1 framing (even parity bit
// after the data bits); undefined gives 8N1.
// Parameters:
//   CLK_DIV : clocks per UART bit (2..65535)
//   FIFO_AW : FIFO address width, depth = 2**FIFO_AW words
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset, effective even mid-frame
//   data_in  : observed word
//   tx       : registered UART line, idle high
//   busy     : FIFO non-empty or a frame in progress
//   overflow : sticky, a change was lost because the FIFO was full
// -----------------------------------------------------------------------------
module out_uart_tx
    import cpu_uart_pkg::*;
#(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    output logic        tx,
    output logic        busy,
    output logic        overflow
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0] prev;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [15:0] fifo_rdata;

    uart_state_t state;
    byte_sel_t   byte_sel;
    logic [15:0] shift_word;
    logic [2:0]  bit_cnt;
    logic [15:0] div_cnt;
    logic        bit_done;
    logic [7:0]  cur_byte;

    // prev resets to zero, so the first nonzero word after reset is a change.
    assign push     = (data_in != prev);
    assign bit_done = (div_cnt == DIV_LAST);
    assign cur_byte = (byte_sel == BYTE_HI) ? shift_word[15:8] : shift_word[7:0];
    assign busy     = (state != IDLE) || !empty;

    // Pop exactly where the FSM loads shift_word from the FIFO head.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            if (state == IDLE)
                pop = 1'b1;
            else if (state == STOP && bit_done && byte_sel == BYTE_LO)
                pop = 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH   (16),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (data_in),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev     <= '0;
            overflow <= 1'b0;
        end else begin
            prev <= data_in;
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    // tx is assigned the level of the state being entered, so the line is a
    // plain flop output and each level lasts exactly CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= IDLE_LEVEL;
            byte_sel   <= BYTE_HI;
            shift_word <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        shift_word <= fifo_rdata;
                        byte_sel   <= BYTE_HI;
                        div_cnt    <= '0;
                        state      <= START;
                        tx         <= START_BIT;
                    end
                end

                START: begin
                    if (bit_done) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                        tx      <= cur_byte[0];
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        div_cnt <= '0;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef OUT_UART_PARITY_EN
                            state <= PARITY;
                            tx    <= even_parity(cur_byte);
`else
                            state <= STOP;
                            tx    <= STOP_BIT;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= cur_byte[bit_cnt + 1'b1];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

`ifdef OUT_UART_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        div_cnt <= '0;
                        state   <= STOP;
                        tx      <= STOP_BIT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (bit_done) begin
                        div_cnt <= '0;
                        if (byte_sel == BYTE_HI) begin
                            byte_sel <= BYTE_LO;
                            state    <= START;
                            tx       <= START_BIT;
                        end else if (!empty) begin
                            // Next word starts straight after this stop bit.
                            shift_word <= fifo_rdata;
                            byte_sel   <= BYTE_HI;
                            state      <= START;
                            tx         <= START_BIT;
                        end else begin
                            state <= IDLE;
                            tx    <= IDLE_LEVEL;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_out_uart_tx
// Self-checking bench for out_uart_tx with CLK_DIV=4, FIFO_AW=2. A serial
// monitor decodes tx into received bytes tagged with their start cycle; the
// main sequence drives data_in from a vector table plus hand-written corner
// cases and compares against hand-computed bytes and cycle numbers.
// Honours OUT_UART_PARITY_EN for 8E1 framing.
// -----------------------------------------------------------------------------
module tb_out_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int FIFO_AW = 2;
`ifdef OUT_UART_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int BYTE_CYC = BITS * CLK_DIV;
    localparam int WORD_CYC = 2 * BYTE_CYC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic        tx;
    logic        busy;
    logic        overflow;

    int cyc = 0;
    int rst_cnt = 0;
    int n_checks = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       frame_ok;
        int         start;
    } rx_t;

    typedef struct {
        logic [15:0] word;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    rx_t  rx_q[$];
    rx_t  mon_r;
    int   mon_rst;
    bit   mon_abort;
    vec_t vecs[5];

    out_uart_tx #(
        .CLK_DIV (CLK_DIV),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) rst_cnt <= rst_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- monitor
    task automatic mon_wait(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin
        forever begin
            mon_wait(1);
            if (rst_n && tx === 1'b0) begin
                mon_r.start    = cyc;
                mon_r.frame_ok = 1'b1;
                mon_r.data     = 8'h00;
                mon_r.par      = 1'b0;
                mon_rst        = rst_cnt;
                mon_abort      = 1'b0;
                for (int k = 0; k < BITS; k++) begin
                    mon_wait((k == 0) ? 2 : CLK_DIV);
                    if (rst_cnt != mon_rst) begin
                        mon_abort = 1'b1;
                        break;
                    end
                    if (k == 0) begin
                        if (tx !== 1'b0) mon_r.frame_ok = 1'b0;
                    end else if (k <= 8) begin
                        mon_r.data[k-1] = tx;
                    end else if (k == BITS - 1) begin
                        if (tx !== 1'b1) mon_r.frame_ok = 1'b0;
                    end else begin
                        mon_r.par = tx;
                    end
                end
                if (!mon_abort) rx_q.push_back(mon_r);
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic wait_idle(input int max, input string nm, output int fall);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max) begin
            tick();
            n++;
        end
        fall = cyc;
        check({nm, "_idle"}, busy, 0);
    endtask

    task automatic check_rx(input string nm, input logic [7:0] exp_data,
                            input int exp_start, output logic par);
        rx_t r;
        par = 1'b0;
        if (rx_q.size() == 0) begin
            check({nm, "_present"}, 0, 1);
            return;
        end
        r   = rx_q.pop_front();
        par = r.par;
        check({nm, "_data"}, {r.frame_ok, r.data}, {1'b1, exp_data});
        check({nm, "_start"}, r.start, exp_start);
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        int   c_push;
        int   fall;
        logic p;
        logic saw;

        vecs[0] = '{word: 16'h1234, hi: 8'h12, lo: 8'h34};
        vecs[1] = '{word: 16'hA55A, hi: 8'hA5, lo: 8'h5A};
        vecs[2] = '{word: 16'h8001, hi: 8'h80, lo: 8'h01};
        vecs[3] = '{word: 16'h0000, hi: 8'h00, lo: 8'h00};
        vecs[4] = '{word: 16'hFFFF, hi: 8'hFF, lo: 8'hFF};

        // Reset state
        rst_n   = 1'b0;
        data_in = 16'h0000;
        repeat (3) tick();
        check("reset_state", {tx, busy, overflow}, 3'b100);
        rst_n = 1'b1;

        // Zero held after reset: never a change, line stays idle
        saw = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) saw = 1'b1;
        end
        check("idle_zero_line", saw, 0);
        check("idle_zero_rx", rx_q.size(), 0);

        // Table: one word at a time from idle
        for (int i = 0; i < 5; i++) begin
            data_in = vecs[i].word;
            c_push  = cyc + 1;
            tick();
            check($sformatf("v%0d_pushed", i), {busy, tx}, 2'b11);
            wait_idle(4 * WORD_CYC, $sformatf("v%0d", i), fall);
            check($sformatf("v%0d_count", i), rx_q.size(), 2);
            check_rx($sformatf("v%0d_hi", i), vecs[i].hi, c_push + 1, p);
            check_rx($sformatf("v%0d_lo", i), vecs[i].lo, c_push + 1 + BYTE_CYC, p);
            check($sformatf("v%0d_busy_fall", i), fall, c_push + 1 + WORD_CYC);
        end

        // Five changes in five cycles fill the FIFO; the sixth is dropped
        c_push = cyc + 1;
        for (int i = 1; i <= 5; i++) begin
            data_in = 16'(i);
            tick();
        end
        check("ovf_before_sixth", overflow, 0);
        data_in = 16'h0006;
        tick();
        check("ovf_set", overflow, 1);
        wait_idle(8 * WORD_CYC, "five", fall);
        check("ovf_sticky", overflow, 1);
        check("five_count", rx_q.size(), 10);
        for (int i = 1; i <= 5; i++) begin
            check_rx($sformatf("five_w%0d_hi", i), 8'h00, c_push + 1 + (i - 1) * WORD_CYC, p);
            check_rx($sformatf("five_w%0d_lo", i), 8'(i), c_push + 1 + (i - 1) * WORD_CYC + BYTE_CYC, p);
        end

        // Reset during the data bits of the high byte of 0xABCD
        data_in = 16'hABCD;
        tick();
        tick();
        check("abcd_started", tx, 0);
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        check("mid_reset_state", {tx, busy, overflow}, 3'b100);
        repeat (5) tick();
        check("mid_reset_no_rx", rx_q.size(), 0);
        rst_n  = 1'b1;
        c_push = cyc + 1;
        tick();
        wait_idle(4 * WORD_CYC, "abcd", fall);
        check("abcd_count", rx_q.size(), 2);
        check_rx("abcd_hi", 8'hAB, c_push + 1, p);
        check_rx("abcd_lo", 8'hCD, c_push + 1 + BYTE_CYC, p);

        // Back-to-back words: no idle bit between them
        data_in = 16'h00FF;
        c_push  = cyc + 1;
        tick();
        data_in = 16'hFF00;
        tick();
        wait_idle(4 * WORD_CYC, "b2b", fall);
        check("b2b_count", rx_q.size(), 4);
        check_rx("b2b_w1_hi", 8'h00, c_push + 1, p);
        check_rx("b2b_w1_lo", 8'hFF, c_push + 1 + BYTE_CYC, p);
        check_rx("b2b_w2_hi", 8'hFF, c_push + 1 + 2 * BYTE_CYC, p);
        check_rx("b2b_w2_lo", 8'h00, c_push + 1 + 3 * BYTE_CYC, p);
        check("b2b_busy_fall", fall, c_push + 1 + 2 * WORD_CYC);

`ifdef OUT_UART_PARITY_EN
        // Even parity: 0x07 -> 1, 0x00 -> 0; 88-cycle word
        data_in = 16'h0700;
        c_push  = cyc + 1;
        tick();
        wait_idle(4 * WORD_CYC, "par", fall);
        check_rx("par_hi", 8'h07, c_push + 1, p);
        check("par_hi_bit", p, 1);
        check_rx("par_lo", 8'h00, c_push + 1 + BYTE_CYC, p);
        check("par_lo_bit", p, 0);
        check("par_word_len", fall - (c_push + 1), 88);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
